// File: rtl/s_machine_pkg.sv
// Shared S-Machine definitions: opcodes, instruction field positions, sequencer states.
package s_machine_pkg;

    localparam int INST_W = 16;

    // Opcode occupies inst[15:12]; src (operand B) and dst (operand A) are 3-bit fields.
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int SRC_LSB = 3;
    localparam int DST_LSB = 0;
    localparam int FIELD_W = 3;

    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // ALU-class opcodes are 01xx; only these are allowed to change registers or PSW.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op & 4'b1100) == 4'b0100;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one debug read port,
// two write ports where port A wins on an address collision.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AW-1:0]     ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [AW-1:0]     rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              wa_en_i,
    input  logic [AW-1:0]     wa_addr_i,
    input  logic [DATA_W-1:0] wa_data_i,
    input  logic              wb_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q;

    // Per-entry write with port-A priority; whole array clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wa_en_i && wa_addr_i == AW'(i))
                    mem_q[i] <= wa_data_i;
                else if (wb_en_i && wb_addr_i == AW'(i))
                    mem_q[i] <= wb_data_i;
            end
        end
    end

    assign ra_data_o  = mem_q[ra_addr_i];
    assign rb_data_o  = mem_q[rb_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / writeback stage around the combinational S-Machine ALU.
// Sequencer IDLE->READ->EXEC->WRITE: one instruction every four cycles.
module alu_operand_stage
    import s_machine_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic              done,
    output logic [15:0]       alu_inst,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic              alu_Z,
    output logic              alu_N,
    output logic              alu_C,
    input  logic [DATA_W-1:0] res_A,
    input  logic [DATA_W-1:0] res_B,
    input  logic              res_Z,
    input  logic              res_N,
    input  logic              res_C,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q, res_a_q, res_b_q;
    logic [2:0]          alu_flags_q, res_flags_q, psw_q;   // {Z,N,C}

    logic [OP_W-1:0]     opcode;
    logic [AW-1:0]       src_addr, dst_addr;
    logic                alu_class;
    logic [DATA_W-1:0]   rd_a, rd_b;

    logic                wa_en, wb_en;
    logic [AW-1:0]       wa_addr;
    logic [DATA_W-1:0]   wa_data;

    assign opcode    = inst_q[OP_LSB +: OP_W];
    assign src_addr  = AW'(inst_q[SRC_LSB +: FIELD_W]);
    assign dst_addr  = AW'(inst_q[DST_LSB +: FIELD_W]);
    assign alu_class = is_alu_op(opcode);

    assign inst_ready = (state_q == IDLE);
    assign done       = (state_q == WRITE);

    // Sequencer state register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: fixed ring, only IDLE waits on the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inst_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: latch inst, fetch operands, capture ALU results, update PSW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_flags_q <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_flags_q <= '0;
            psw_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (inst_valid) inst_q <= inst;
                READ: begin
                    alu_a_q     <= rd_a;
                    alu_b_q     <= rd_b;
                    alu_flags_q <= psw_q;
                end
                EXEC: begin
                    res_a_q     <= res_A;
                    res_b_q     <= res_B;
                    res_flags_q <= {res_Z, res_N, res_C};
                end
                WRITE: if (alu_class) psw_q <= res_flags_q;
                default: ;
            endcase
        end
    end

    // Write port A carries the preload in IDLE and the dst writeback in WRITE;
    // port B only carries the SWAP second result.
    always_comb begin
        wa_en   = 1'b0;
        wa_addr = ld_addr;
        wa_data = ld_data;
        wb_en   = 1'b0;
        if (state_q == IDLE) begin
            wa_en = ld_en;
        end else if (state_q == WRITE) begin
            wa_en   = alu_class;
            wa_addr = dst_addr;
            wa_data = res_a_q;
            wb_en   = (opcode == OP_SWAP);
        end
    end

    reg_file #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_rf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ra_addr_i  (dst_addr),
        .ra_data_o  (rd_a),
        .rb_addr_i  (src_addr),
        .rb_data_o  (rd_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .wa_en_i    (wa_en),
        .wa_addr_i  (wa_addr),
        .wa_data_i  (wa_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (src_addr),
        .wb_data_i  (res_b_q)
    );

    assign alu_inst = inst_q;
    assign alu_A    = alu_a_q;
    assign alu_B    = alu_b_q;
    assign {alu_Z, alu_N, alu_C} = alu_flags_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: drives a stub ALU, keeps a transaction-level
// model of registers/PSW/handshake, and checks the DUT on every falling edge.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inst_valid, inst_ready, done;
    logic [15:0] inst, alu_inst, alu_A, alu_B, res_A, res_B, ld_data, dbg_data;
    logic        alu_Z, alu_N, alu_C, res_Z, res_N, res_C, ld_en;
    logic [2:0]  ld_addr, dbg_addr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .done(done), .alu_inst(alu_inst), .alu_A(alu_A), .alu_B(alu_B),
        .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .res_A(res_A), .res_B(res_B),
        .res_Z(res_Z), .res_N(res_N), .res_C(res_C), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub ALU returning {res_A, res_B, Z, N, C}. SWAP returns ~A on B and
    // non-ALU opcodes return inverted data with all flags set, so any write
    // the stage should have discarded becomes visible.
    function automatic logic [34:0] alu_stub(input logic [15:0] i, input logic [15:0] a,
                                             input logic [15:0] b, input logic [2:0] f);
        logic [16:0] w;
        logic [15:0] ra, rb;
        logic [2:0]  fo;
        ra = ~a; rb = ~b; fo = 3'b111; w = '0;
        case (i[15:12])
            4'h4: begin w = {1'b0, a} + {1'b0, b}; ra = w[15:0]; rb = b; fo = {ra == 16'h0, ra[15], w[16]}; end
            4'h5: begin w = {1'b0, a} - {1'b0, b}; ra = w[15:0]; rb = b; fo = {ra == 16'h0, ra[15], w[16]}; end
            4'h7: begin ra = b; rb = ~a; fo = f; end
            default: ;
        endcase
        return {ra, rb, fo};
    endfunction

    always_comb {res_A, res_B, res_Z, res_N, res_C} = alu_stub(alu_inst, alu_A, alu_B, {alu_Z, alu_N, alu_C});

    // Model: busy counts cycles left in the current instruction (3 after accept).
    logic [15:0] m_reg [8];
    logic [2:0]  m_psw, m_f;
    logic [15:0] m_inst, m_A, m_B;
    logic [34:0] m_r;
    int          m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) m_reg[k] = '0;
            m_psw = '0; m_f = '0; m_inst = '0; m_A = '0; m_B = '0; m_busy = 0;
        end else begin
            case (m_busy)
                0: begin
                    if (ld_en) m_reg[ld_addr] = ld_data;
                    if (inst_valid) begin m_inst = inst; m_busy = 3; end
                end
                3: begin
                    m_A = m_reg[m_inst[2:0]]; m_B = m_reg[m_inst[5:3]]; m_f = m_psw; m_busy = 2;
                end
                2: m_busy = 1;
                default: begin
                    m_r = alu_stub(m_inst, m_A, m_B, m_f);
                    if (m_inst[15:14] == 2'b01) begin
                        if (m_inst[15:12] == 4'h7) m_reg[m_inst[5:3]] = m_r[18:3];
                        m_reg[m_inst[2:0]] = m_r[34:19];
                        m_psw = m_r[2:0];
                    end
                    m_busy = 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ready",    inst_ready, m_busy == 0);
            check("done",     done, m_busy == 1);
            check("alu_inst", alu_inst, m_inst);
            check("alu_A",    alu_A, m_A);
            check("alu_B",    alu_B, m_B);
            check("alu_flags", {alu_Z, alu_N, alu_C}, m_f);
            check("dbg_data", dbg_data, m_reg[dbg_addr]);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        dbg_addr = dbg_addr + 3'd1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int already);
        int lat;
        lat = 0;
        for (int k = already + 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        check({name, "_latency"}, lat, exp_lat);
        tick();
    endtask

    task automatic run_inst(input string name, input logic [15:0] i);
        inst = i; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0; inst = 16'hFFFF;   // must be ignored while busy
        wait_done(name, 3, 0);
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a; #1;
        check(name, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] done_mask;
        int          seen;
        inst_valid = 1'b0; inst = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;

        // 1: reset state
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            check("rst_dbg", dbg_data, 16'h0);
        end
        check("rst_ready", inst_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_flags", {alu_Z, alu_N, alu_C}, 3'b000);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // 2: ADD R0 = R0 + R1
        preload(3'd0, 16'd1); preload(3'd1, 16'd1);
        run_inst("add", 16'h4008);
        peek("add_r0", 3'd0, 16'd2);
        peek("add_r1", 3'd1, 16'd1);

        // 3: SUB to zero, then an ADD must see Z=1 on its operands
        preload(3'd0, 16'd1);
        run_inst("sub", 16'h5008);
        peek("sub_r0", 3'd0, 16'd0);
        inst = 16'h4008; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        check("sub_z_fwd", {alu_Z, alu_N, alu_C}, 3'b100);
        wait_done("add2", 3, 1);
        peek("add2_r0", 3'd0, 16'd1);

        // 4: SWAP with src == dst: the A result wins
        preload(3'd2, 16'd5);
        run_inst("swap", 16'h7012);
        peek("swap_r2", 3'd2, 16'd5);

        // 5: non-ALU opcode changes nothing; held valid gives one accept per 4 cycles
        preload(3'd0, 16'h1234);
        run_inst("nonalu", 16'h0008);
        peek("nonalu_r0", 3'd0, 16'h1234);
        done_mask = '0; seen = 0;
        inst = 16'h0008; inst_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            @(negedge clk);
            done_mask[k-1] = done;
            if (inst_ready) seen++;
        end
        inst_valid = 1'b0;
        check("b2b_done_mask", done_mask, 12'h444);
        check("b2b_ready_cnt", seen, 3);
        tick();
        peek("b2b_r0", 3'd0, 16'h1234);

        // 6: reset while the ADD is in EXEC
        preload(3'd0, 16'd3); preload(3'd1, 16'd4);
        inst = 16'h4008; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rstmid_done", seen, 0);
        check("rstmid_ready", inst_ready, 1'b1);
        peek("rstmid_r0", 3'd0, 16'd0);
        peek("rstmid_r1", 3'd1, 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        preload(3'd0, 16'd7);
        run_inst("post_rst_add", 16'h4008);
        peek("post_rst_r0", 3'd0, 16'd7);

        tick(); tick();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
